// File: rtl/load_store_unit_if.sv
// Bus bundles for the load/store unit: core-side request/response and data-RAM side.
// In each bundle, the master modport is the side that issues requests.

interface lsu_core_if #(
    parameter int SIZE = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [SIZE-1:0] req_addr;
    logic [SIZE-1:0] req_wdata;
    logic            resp_valid;
    logic [SIZE-1:0] resp_rdata;
    logic            resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if #(
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  mem_valid;
    logic                  mem_ready;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [SIZE-1:0]       mem_wdata;
    logic [SIZE-1:0]       mem_rdata;
    logic                  mem_rvalid;

    modport master (
        output mem_valid, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata, mem_rvalid
    );

    modport slave (
        input  mem_valid, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ready, mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core request into a single word-wide RAM transaction with
// lane steering, load extension, misalignment checks and an optional timeout.
//
//   state  | meaning
//   IDLE   | ready for a core request
//   REQ    | memory request presented, waiting for mem_ready
//   WAIT_R | load accepted by memory, waiting for mem_rvalid
//   DONE   | one-cycle response to the core

module load_store_unit #(
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 64
) (
    input logic        clk,
    input logic        reset_n,
    lsu_core_if.slave  core,
    lsu_mem_if.master  mem
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [SIZE-1:0]       wdata_q;
    logic [SIZE-1:0]       rdata_q;
    logic                  err_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  accept;
    logic                  bad_req;
    logic                  capture;
    logic                  timed_out;
    logic                  tc;
    logic [SIZE-1:0]       load_fmt;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;

    assign tc = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        bad_req = 1'b0;
        case (core.req_funct3)
            3'b000:  bad_req = 1'b0;
            3'b001:  bad_req = core.req_addr[0];
            3'b010:  bad_req = (core.req_addr[1:0] != 2'b00);
            3'b100:  bad_req = core.req_we;
            3'b101:  bad_req = core.req_we | core.req_addr[0];
            default: bad_req = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        timed_out = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (core.req_valid) begin
                    accept  = 1'b1;
                    state_d = bad_req ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem.mem_ready) begin
                    if (we_q) begin
                        state_d = DONE;
                    end else if (mem.mem_rvalid) begin
                        capture = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_R;
                    end
                end else if (tc) begin
                    timed_out = 1'b1;
                    state_d   = DONE;
                end
            end
            WAIT_R: begin
                if (mem.mem_rvalid) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else if (tc) begin
                    timed_out = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane selection from the latched byte offset; extension chosen by funct3.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    sel_byte = mem.mem_rdata[7:0];
            2'd1:    sel_byte = mem.mem_rdata[15:8];
            2'd2:    sel_byte = mem.mem_rdata[23:16];
            default: sel_byte = mem.mem_rdata[31:24];
        endcase
        sel_half = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_fmt = {{(SIZE-8){sel_byte[7]}}, sel_byte};
            3'b001:  load_fmt = {{(SIZE-16){sel_half[15]}}, sel_half};
            3'b100:  load_fmt = {{(SIZE-8){1'b0}}, sel_byte};
            3'b101:  load_fmt = {{(SIZE-16){1'b0}}, sel_half};
            default: load_fmt = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= core.req_we;
                funct3_q <= core.req_funct3;
                addr_q   <= core.req_addr[ADDR_WIDTH+1:0];
                wdata_q  <= core.req_wdata;
                rdata_q  <= '0;
                err_q    <= bad_req;
                cnt_q    <= '0;
            end else if (state_q == REQ || state_q == WAIT_R) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (capture) begin
                rdata_q <= load_fmt;
            end
            if (timed_out) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        core.req_ready  = (state_q == IDLE);
        core.resp_valid = 1'b0;
        core.resp_rdata = '0;
        core.resp_err   = 1'b0;
        mem.mem_valid   = 1'b0;
        mem.mem_we      = 1'b0;
        mem.mem_be      = 4'b0000;
        mem.mem_addr    = '0;
        mem.mem_wdata   = '0;
        if (state_q == REQ) begin
            mem.mem_valid = 1'b1;
            mem.mem_we    = we_q;
            mem.mem_addr  = addr_q[ADDR_WIDTH+1:2];
            case (funct3_q[1:0])
                2'b00: begin
                    mem.mem_be    = 4'b0001 << addr_q[1:0];
                    mem.mem_wdata = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    mem.mem_be    = 4'b0011 << addr_q[1:0];
                    mem.mem_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    mem.mem_be    = 4'b1111;
                    mem.mem_wdata = wdata_q;
                end
            endcase
        end
        if (state_q == DONE) begin
            core.resp_valid = 1'b1;
            core.resp_rdata = rdata_q;
            core.resp_err   = err_q;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: response expectations are queued when a request
// is issued and compared when the response pulse appears.

module tb_load_store_unit;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    lsu_core_if #(.SIZE(32))                  core_bus ();
    lsu_mem_if  #(.SIZE(32), .ADDR_WIDTH(10)) mem_bus ();
    lsu_core_if #(.SIZE(32))                  tcore ();
    lsu_mem_if  #(.SIZE(32), .ADDR_WIDTH(10)) tmem ();

    load_store_unit #(.SIZE(32), .ADDR_WIDTH(10), .TIMEOUT(64)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .core    (core_bus.slave),
        .mem     (mem_bus.master)
    );

    load_store_unit #(.SIZE(32), .ADDR_WIDTH(10), .TIMEOUT(4)) u_tmo (
        .clk     (clk),
        .reset_n (reset_n),
        .core    (tcore.slave),
        .mem     (tmem.master)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb[$];
    int    vectors     = 0;
    int    miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err);
        resp_t r;
        check("req_ready", {31'b0, core_bus.req_ready}, 32'd1);
        core_bus.req_valid  = 1'b1;
        core_bus.req_we     = we;
        core_bus.req_funct3 = f3;
        core_bus.req_addr   = addr;
        core_bus.req_wdata  = wdata;
        r.rdata = exp_rdata;
        r.err   = exp_err;
        sb.push_back(r);
        tick();
        core_bus.req_valid = 1'b0;
        core_bus.req_wdata = 32'h0;
    endtask

    task automatic check_mem(input string tag, input logic we, input logic [3:0] be,
                             input logic [9:0] addr, input logic [31:0] wdata);
        check({tag, "_mvalid"}, {31'b0, mem_bus.mem_valid}, 32'd1);
        check({tag, "_mwe"},    {31'b0, mem_bus.mem_we}, {31'b0, we});
        check({tag, "_mbe"},    {28'b0, mem_bus.mem_be}, {28'b0, be});
        check({tag, "_maddr"},  {22'b0, mem_bus.mem_addr}, {22'b0, addr});
        check({tag, "_mwdata"}, mem_bus.mem_wdata, wdata);
    endtask

    task automatic check_resp(input string tag);
        resp_t e;
        check({tag, "_rvalid"}, {31'b0, core_bus.resp_valid}, 32'd1);
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed a response, expected none queued", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_rdata"}, core_bus.resp_rdata, e.rdata);
            check({tag, "_err"}, {31'b0, core_bus.resp_err}, {31'b0, e.err});
        end
    endtask

    task automatic check_no_resp(input string tag);
        check({tag, "_noresp"}, {31'b0, core_bus.resp_valid}, 32'd0);
    endtask

    task automatic wait_resp(input string tag, input int budget);
        int n = 0;
        while (!core_bus.resp_valid && n < budget) begin
            tick();
            n++;
        end
        if (core_bus.resp_valid) begin
            check_resp(tag);
        end else begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed no response after %0d cycles, expected resp_valid", tag, budget);
        end
    endtask

    task automatic load_zero_wait(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] word, input logic [31:0] exp);
        issue(1'b0, f3, addr, 32'h0, exp, 1'b0);
        check({tag, "_c1_mvalid"}, {31'b0, mem_bus.mem_valid}, 32'd1);
        mem_bus.mem_ready = 1'b1;
        tick();
        mem_bus.mem_ready = 1'b0;
        check({tag, "_c2_mvalid"}, {31'b0, mem_bus.mem_valid}, 32'd0);
        check_no_resp({tag, "_c2"});
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = word;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = 32'h0;
        check_resp({tag, "_c3"});
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        core_bus.req_valid  = 1'b0;
        core_bus.req_we     = 1'b0;
        core_bus.req_funct3 = 3'b000;
        core_bus.req_addr   = 32'h0;
        core_bus.req_wdata  = 32'h0;
        mem_bus.mem_ready   = 1'b0;
        mem_bus.mem_rvalid  = 1'b0;
        mem_bus.mem_rdata   = 32'h0;
        tcore.req_valid     = 1'b0;
        tcore.req_we        = 1'b0;
        tcore.req_funct3    = 3'b000;
        tcore.req_addr      = 32'h0;
        tcore.req_wdata     = 32'h0;
        tmem.mem_ready      = 1'b0;
        tmem.mem_rvalid     = 1'b0;
        tmem.mem_rdata      = 32'h0;

        reset_n = 1'b0;
        tick();
        tick();
        check("rst_req_ready", {31'b0, core_bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, core_bus.resp_valid}, 32'd0);
        check("rst_mem_valid", {31'b0, mem_bus.mem_valid}, 32'd0);
        check("rst_mem_be", {28'b0, mem_bus.mem_be}, 32'd0);
        check("rst_mem_wdata", mem_bus.mem_wdata, 32'd0);
        reset_n = 1'b1;
        tick();

        // SW, zero-wait memory
        issue(1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0, 1'b0);
        check_mem("sw_c1", 1'b1, 4'b1111, 10'd2, 32'hDEAD_BEEF);
        check_no_resp("sw_c1");
        mem_bus.mem_ready = 1'b1;
        tick();
        mem_bus.mem_ready = 1'b0;
        check_resp("sw_c2");
        check("sw_c2_mvalid", {31'b0, mem_bus.mem_valid}, 32'd0);
        tick();

        // SB to the top lane
        issue(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 32'h0, 1'b0);
        check_mem("sb_c1", 1'b1, 4'b1000, 10'd4, 32'hA5A5_A5A5);
        mem_bus.mem_ready = 1'b1;
        tick();
        mem_bus.mem_ready = 1'b0;
        check_resp("sb_c2");
        tick();

        // SH to the upper half
        issue(1'b1, 3'b001, 32'h0000_0026, 32'h1234_BEEF, 32'h0, 1'b0);
        check_mem("sh_c1", 1'b1, 4'b1100, 10'd9, 32'hBEEF_BEEF);
        mem_bus.mem_ready = 1'b1;
        tick();
        mem_bus.mem_ready = 1'b0;
        check_resp("sh_c2");
        tick();

        // Loads with one-cycle read latency
        issue(1'b0, 3'b000, 32'h0000_0001, 32'h0, 32'hFFFF_FF80, 1'b0);
        check_mem("lb_c1", 1'b0, 4'b0010, 10'd0, 32'h0);
        mem_bus.mem_ready = 1'b1;
        tick();
        mem_bus.mem_ready = 1'b0;
        check_no_resp("lb_c2");
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'h0000_8000;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        check_resp("lb_c3");
        tick();

        load_zero_wait("lbu", 3'b100, 32'h0000_0001, 32'h0000_8000, 32'h0000_0080);
        load_zero_wait("lhu", 3'b101, 32'h0000_0002, 32'h8001_0000, 32'h0000_8001);
        load_zero_wait("lh",  3'b001, 32'h0000_0002, 32'h8001_0000, 32'hFFFF_8001);
        load_zero_wait("lw",  3'b010, 32'h0000_0004, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // LW with ready and rvalid in the same cycle
        issue(1'b0, 3'b010, 32'h0000_000C, 32'h0, 32'h0BAD_CAFE, 1'b0);
        mem_bus.mem_ready  = 1'b1;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'h0BAD_CAFE;
        tick();
        mem_bus.mem_ready  = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        check_resp("lw_fast_c2");
        tick();

        // Errors: no memory transaction, response in cycle 1
        issue(1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 1'b1);
        check("lwmis_mvalid", {31'b0, mem_bus.mem_valid}, 32'd0);
        check_resp("lwmis_c1");
        tick();
        issue(1'b1, 3'b100, 32'h0000_0000, 32'h1111_2222, 32'h0, 1'b1);
        check("sbad_mvalid", {31'b0, mem_bus.mem_valid}, 32'd0);
        check_resp("sbad_c1");
        tick();
        issue(1'b0, 3'b101, 32'h0000_0003, 32'h0, 32'h0, 1'b1);
        check_resp("lhumis_c1");
        tick();

        // Stalled memory: outputs held until ready, then slow read data
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_mem("stall", 1'b0, 4'b1111, 10'd4, 32'h0);
            check_no_resp("stall");
            tick();
        end
        check_mem("stall_rdy", 1'b0, 4'b1111, 10'd4, 32'h0);
        mem_bus.mem_ready = 1'b1;
        tick();
        mem_bus.mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("stall_wait_mvalid", {31'b0, mem_bus.mem_valid}, 32'd0);
            check_no_resp("stall_wait");
            tick();
        end
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'h1234_5678;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        check_resp("stall_resp");
        tick();
        check_no_resp("stall_single_pulse");

        // Timeout on the TIMEOUT=4 instance, memory never ready
        check("tmo_ready", {31'b0, tcore.req_ready}, 32'd1);
        tcore.req_valid  = 1'b1;
        tcore.req_funct3 = 3'b010;
        tcore.req_addr   = 32'h0000_0040;
        tick();
        tcore.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("tmo_mvalid", {31'b0, tmem.mem_valid}, 32'd1);
            check("tmo_noresp", {31'b0, tcore.resp_valid}, 32'd0);
            tick();
        end
        check("tmo_resp_valid", {31'b0, tcore.resp_valid}, 32'd1);
        check("tmo_resp_err", {31'b0, tcore.resp_err}, 32'd1);
        check("tmo_resp_rdata", tcore.resp_rdata, 32'd0);
        check("tmo_mvalid_drop", {31'b0, tmem.mem_valid}, 32'd0);
        tick();
        check("tmo_idle", {31'b0, tcore.req_ready}, 32'd1);

        // Reset during WAIT_R abandons the load
        issue(1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'h0, 1'b0);
        mem_bus.mem_ready = 1'b1;
        tick();
        mem_bus.mem_ready = 1'b0;
        check("rstw_in_wait", {31'b0, core_bus.req_ready}, 32'd0);
        reset_n = 1'b0;
        tick();
        sb.delete();
        reset_n = 1'b1;
        check("rstw_ready", {31'b0, core_bus.req_ready}, 32'd1);
        check_no_resp("rstw_c1");
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'hFFFF_FFFF;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        check_no_resp("rstw_late_rvalid");
        check("rstw_ready2", {31'b0, core_bus.req_ready}, 32'd1);

        issue(1'b0, 3'b100, 32'h0000_0023, 32'h0, 32'h0000_00C3, 1'b0);
        mem_bus.mem_ready = 1'b1;
        tick();
        mem_bus.mem_ready  = 1'b0;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'hC300_0000;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        wait_resp("post_rst", 10);
        tick();

        check("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
